div5_word_serializer: RTL
=========================

Name: div5_word_serializer

Overview:
Upstream feeder for the serial divisible-by-5 detector. Accepts parallel words over a valid/ready handshake and emits them MSB-first as a one-bit stream (ser_bit -> detector din). It also emits frame markers, so the downstream stage can restart its remainder state at each word boundary. A one-entry holding register allows gapless back-to-back words.

Parameters:
W, 8, word width in bits; legal range 2..32.
GAP, 0, idle cycles inserted between consecutive words; legal range 0..15.

Ports:
clk  in  1  clock; all logic on posedge.
resetn  in  1  synchronous, active-low reset.
in_data  in  W  parallel word to serialize.
in_valid  in  1  in_data valid.
in_ready  out  1  block can accept a word; = ~hold_vld, forced 0 while resetn low.
ser_bit  out  1  current serial bit; registered.
ser_valid  out  1  ser_bit valid this cycle.
ser_first  out  1  ser_bit is bit 0 of a word (MSB).
ser_last  out  1  ser_bit is bit W-1 of a word (LSB).
busy  out  1  state != IDLE or hold_vld.

Behaviour:
- Reset (resetn=0 at posedge): state=IDLE, hold_vld=0, shift_reg=0, bit_cnt=0, gap_cnt=0. All outputs are 0 in the following cycle. Any handshake coinciding with reset is discarded. Reset mid-word aborts the word with no further bits.
- Handshake: a word is accepted at a posedge with in_valid && in_ready. in_data must be held while in_valid=1 && in_ready=0.
- States:
  - IDLE: ser_valid=0.
  - SHIFT: ser_valid=1; bit_cnt runs 0..W-1.
  - GAP: ser_valid=0; gap_cnt runs 0..GAP-1.
- Load event occurs at a posedge when any of these holds:
  - state=IDLE;
  - state=SHIFT && bit_cnt=W-1 && GAP=0;
  - state=GAP && gap_cnt=GAP-1.
- Load source: hold_reg if hold_vld, else in_data if a handshake occurs at the same edge. If neither is available, the next state is IDLE (from SHIFT/GAP) or stays IDLE.
- On a load: shift_reg <= source, bit_cnt <= 0, state <= SHIFT.
- Hold register:
  - An accepted word not consumed by a load at that edge is written to hold_reg (hold_vld<=1).
  - If hold_reg is loaded into the shifter at an edge where a new handshake also occurs, hold_reg takes the new word and hold_vld stays 1.
  - If hold_reg is loaded with no handshake at that edge, hold_vld<=0.
- SHIFT, non-last bit: shift_reg shifts left by 1 and bit_cnt increments.
- SHIFT, last bit without a load: goes to GAP (GAP>0) with gap_cnt<=0, or to IDLE.
- ser_bit = shift_reg[W-1].
- ser_first = ser_valid && bit_cnt==0.
- ser_last = ser_valid && bit_cnt==W-1.
- Latency: a handshake at edge N while IDLE with hold empty gives the first bit (ser_first=1) in cycle N+1. The last bit appears in cycle N+W.
- Throughput: with GAP=0 and the source keeping up, ser_valid stays continuously high. The word period is W+GAP cycles.
- No backpressure from downstream: the stream is consumed every cycle.
- Counters are sized $clog2(W) and $clog2(GAP+1) (minimum 1 bit). No wrap past the terminal values.

Optional Feature:
- Macro: DIV5_SER_LSB_FIRST_EN.
- Defined: shift_reg shifts right and ser_bit = shift_reg[0], so the LSB is sent first. ser_first/ser_last still mark the first/last transmitted bit.
- Undefined: MSB-first as specified above. This is the required order for correct modulo detection downstream.

Test Plan:
- W=8, GAP=0: single word 8'h05 accepted while IDLE -> ser_bit = 0,0,0,0,0,1,0,1 in cycles N+1..N+8; ser_first only at N+1; ser_last only at N+8; IDLE and busy=0 at N+9.
- W=8, GAP=0, in_valid held high with 8'h0A then 8'h0F -> 16 contiguous ser_valid cycles; ser_first at cycles 1 and 9; in_ready low while hold full; no word dropped or duplicated.
- W=8, GAP=2, two back-to-back words -> exactly 2 cycles with ser_valid=0 between ser_last of word 1 and ser_first of word 2.
- Backpressure: hold full and in_valid=1 with in_data 8'hFF held -> in_ready=0 until the hold is consumed at a load edge; the word is accepted on the first edge with in_ready=1 and appears intact afterwards.
- Reset mid-operation: resetn=0 for one edge at bit_cnt=3 with hold_vld=1 -> next cycle all outputs 0, in_ready=1 after resetn returns; the next accepted word 8'h14 serializes from ser_first normally.
- With DIV5_SER_LSB_FIRST_EN defined, word 8'h05 -> ser_bit = 1,0,1,0,0,0,0,0.

Source files
------------

// File: rtl/div5_word_serializer.sv
// Word-to-bit serializer feeding the divisible-by-5 detector, with frame markers and a
// one-entry holding register. Define DIV5_SER_LSB_FIRST_EN to transmit LSB-first.
module div5_word_serializer #(
    parameter int unsigned W   = 8,
    parameter int unsigned GAP = 0
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic         ser_bit,
    output logic         ser_valid,
    output logic         ser_first,
    output logic         ser_last,
    output logic         busy
);

    localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;
    localparam int unsigned GW = (GAP > 0) ? $clog2(GAP + 1) : 1;
    localparam logic [CW-1:0] BitLast = CW'(W - 1);
    localparam logic [GW-1:0] GapLast = GW'((GAP > 0) ? GAP - 1 : 0);

    typedef enum logic [1:0] {StIdle, StShift, StGap} state_e;

    state_e        state_q, state_d;
    logic [W-1:0]  shift_q, shift_d;
    logic [W-1:0]  hold_q, hold_d;
    logic          hold_vld_q, hold_vld_d;
    logic [CW-1:0] bit_cnt_q, bit_cnt_d;
    logic [GW-1:0] gap_cnt_q, gap_cnt_d;
    logic          hs;
    logic          load_evt;
    logic [W-1:0]  shifted;

    assign in_ready = resetn && !hold_vld_q;
    assign hs       = in_valid && in_ready;

`ifdef DIV5_SER_LSB_FIRST_EN
    assign shifted = {1'b0, shift_q[W-1:1]};
    assign ser_bit = shift_q[0];
`else
    assign shifted = {shift_q[W-2:0], 1'b0};
    assign ser_bit = shift_q[W-1];
`endif

    assign load_evt = (state_q == StIdle)
                   || (state_q == StShift && bit_cnt_q == BitLast && GAP == 0)
                   || (state_q == StGap && gap_cnt_q == GapLast);

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        hold_d     = hold_q;
        hold_vld_d = hold_vld_q;
        bit_cnt_d  = bit_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        if (load_evt) begin
            if (hold_vld_q) begin
                // Held word goes first; a same-edge handshake refills the hold.
                shift_d    = hold_q;
                bit_cnt_d  = '0;
                state_d    = StShift;
                hold_vld_d = hs;
                if (hs) hold_d = in_data;
            end else if (hs) begin
                shift_d   = in_data;
                bit_cnt_d = '0;
                state_d   = StShift;
            end else begin
                state_d = StIdle;
            end
        end else begin
            if (hs) begin
                hold_d     = in_data;
                hold_vld_d = 1'b1;
            end
            unique case (state_q)
                StShift: begin
                    if (bit_cnt_q == BitLast) begin
                        if (GAP > 0) begin
                            state_d   = StGap;
                            gap_cnt_d = '0;
                        end else begin
                            state_d = StIdle;
                        end
                    end else begin
                        shift_d   = shifted;
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
                StGap:   gap_cnt_d = gap_cnt_q + 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= StIdle;
            shift_q    <= '0;
            hold_q     <= '0;
            hold_vld_q <= 1'b0;
            bit_cnt_q  <= '0;
            gap_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            hold_q     <= hold_d;
            hold_vld_q <= hold_vld_d;
            bit_cnt_q  <= bit_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
        end
    end

    assign ser_valid = (state_q == StShift);
    assign ser_first = ser_valid && (bit_cnt_q == '0);
    assign ser_last  = ser_valid && (bit_cnt_q == BitLast);
    assign busy      = (state_q != StIdle) || hold_vld_q;

endmodule
